// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select pipe.
//  - SRC_* : source indices matching the legacy 2-bit writeback encoding
//  - wb_req_t : writeback request payload at the default 16-bit/4-bit configuration
//  - wb_state_e : occupancy state of the two-entry skid buffer
//  - sel_is_legal : true when an encoded select addresses an existing source
package wb_pkg;

  localparam int SRC_ALU   = 0;
  localparam int SRC_SHIFT = 1;
  localparam int SRC_REG   = 2;
  localparam int SRC_MEM   = 3;

  localparam int WB_DATA_W = 16;
  localparam int WB_DEST_W = 4;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_DEST_W-1:0] dest;
    logic                 wen;
  } wb_req_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } wb_state_e;

  function automatic logic sel_is_legal(input int unsigned sel_v, input int unsigned num_src);
    return (sel_v < num_src) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/wb_select_pipe_if.sv
// Bus bundle for wb_select_pipe.
//  Producer side: in_valid/in_ready handshake, packed src_data, sel, in_dest, in_wen.
//  Consumer side: out_valid/out_ready handshake, out_data, out_dest, out_wen.
//  sel_err is a one-cycle status pulse reported by the block.
//  master = the environment driving requests and consuming results; slave = the block.
interface wb_select_pipe_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int RADDR_W = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         sel;
  logic [RADDR_W-1:0]       in_dest;
  logic                     in_wen;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [RADDR_W-1:0]       out_dest;
  logic                     out_wen;
  logic                     sel_err;

  modport master (
    output in_valid, src_data, sel, in_dest, in_wen, out_ready,
    input  in_ready, out_valid, out_data, out_dest, out_wen, sel_err
  );

  modport slave (
    input  in_valid, src_data, sel, in_dest, in_wen, out_ready,
    output in_ready, out_valid, out_data, out_dest, out_wen, sel_err
  );

endinterface

// File: rtl/wb_skid_buf.sv
// Generic two-entry valid/ready skid buffer.
//  Main register M drives the outputs; skid register S absorbs one extra request so
//  in_ready depends only on registered occupancy, never on out_ready.
// Ports:
//  clk, reset           rising-edge clock, synchronous active-high reset
//  in_valid/in_ready    upstream handshake, in_data payload (P_W bits)
//  out_valid/out_ready  downstream handshake, out_data payload (P_W bits)
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int P_W = 21
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_data
);

  wb_state_e      state_q, state_d;
  logic [P_W-1:0] m_q, m_d;
  logic [P_W-1:0] s_q, s_d;
  logic           accept_s;
  logic           drain_s;

  assign accept_s = in_valid & in_ready;
  assign drain_s  = out_valid & out_ready;

  // State and storage registers; reset discards any buffered requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Next occupancy and register loads.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_ONE;
          m_d     = in_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          m_d = in_data;
        end else if (accept_s) begin
          // Consumer stalled: park the newer request behind M.
          state_d = ST_TWO;
          s_d     = in_data;
        end else if (drain_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          state_d = ST_ONE;
          m_d     = s_q;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Handshake outputs derived from registered occupancy only.
  always_comb begin
    in_ready  = (state_q != ST_TWO) && !reset;
    out_valid = (state_q != ST_EMPTY);
    out_data  = m_q;
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback-source selector: picks one of NUM_SRC result buses by encoded select,
// bundles it with destination register and write enable, and hands it to the
// register file through a two-entry skid buffer (registered outputs, 1-cycle latency).
// Ports:
//  clk    rising-edge clock
//  reset  synchronous active-high reset, clears all state
//  bus    wb_select_pipe_if.slave: request in, writeback out, sel_err pulse
// An out-of-range select is still accepted but delivers data 0 with wen forced low,
// and raises sel_err for one cycle after the accept.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int RADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_select_pipe_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [RADDR_W-1:0] dest;
    logic               wen;
  } req_t;

  localparam int P_W = $bits(req_t);

  logic [WIDTH-1:0] src_arr [NUM_SRC];
  logic [SEL_W-1:0] sel_s;
  logic             sel_ok_s;
  logic             accept_s;
  req_t             req_s;
  req_t             out_req_s;
  logic             sel_err_d, sel_err_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_arr[k] = bus.src_data[k*WIDTH +: WIDTH];
  end

  assign sel_s    = bus.sel;
  assign accept_s = bus.in_valid & bus.in_ready;

  // Source selection and illegal-select masking.
  always_comb begin
    sel_ok_s   = sel_is_legal(32'(sel_s), NUM_SRC);
    req_s.dest = bus.in_dest;
    if (sel_ok_s) begin
      req_s.data = src_arr[sel_s];
      req_s.wen  = bus.in_wen;
    end else begin
      req_s.data = '0;
      req_s.wen  = 1'b0;
    end
    sel_err_d = accept_s & ~sel_ok_s;
  end

  // Error pulse register: one cycle after an accepted illegal select.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  wb_skid_buf #(
    .P_W (P_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (req_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_req_s)
  );

  assign bus.out_data = out_req_s.data;
  assign bus.out_dest = out_req_s.dest;
  assign bus.out_wen  = out_req_s.wen;
  assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: three instances cover the default 4-source
// configuration, a 3-source configuration with an unused select code, and a
// 32-bit 8-source configuration exercised with random valid/ready against a queue.
module tb_wb_select_pipe;
  import wb_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wb_select_pipe_if #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .RADDR_W(4)) bus_a ();
  wb_select_pipe_if #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2), .RADDR_W(4)) bus_b ();
  wb_select_pipe_if #(.WIDTH(32), .NUM_SRC(8), .SEL_W(3), .RADDR_W(4)) bus_c ();

  wb_select_pipe #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .RADDR_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  wb_select_pipe #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2), .RADDR_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );
  wb_select_pipe #(.WIDTH(32), .NUM_SRC(8), .SEL_W(3), .RADDR_W(4)) u_dut_c (
    .clk(clk), .reset(reset), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_a [4];
  logic [31:0] c_src [8];
  logic [36:0] sb_q [$];
  logic [36:0] exp_c;
  logic [2:0]  c_sel;
  logic        c_taken;

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_a[0] = 16'hAAAA; exp_a[1] = 16'hBBBB; exp_a[2] = 16'hCCCC; exp_a[3] = 16'hDDDD;
    reset = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.src_data = '0; bus_a.sel = 2'd0; bus_a.in_dest = 4'd0;
    bus_a.in_wen = 1'b0;   bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.src_data = '0; bus_b.sel = 2'd0; bus_b.in_dest = 4'd0;
    bus_b.in_wen = 1'b0;   bus_b.out_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.src_data = '0; bus_c.sel = 3'd0; bus_c.in_dest = 4'd0;
    bus_c.in_wen = 1'b0;   bus_c.out_ready = 1'b0;

    // 1: reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check_vec("rst_out_data", 64'(bus_a.out_data), 64'd0);
      check_vec("rst_sel_err", 64'(bus_a.sel_err), 64'd0);
      check_vec("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    end
    reset = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    check_vec("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);

    // 2: each source back-to-back with out_ready high
    @(negedge clk);
    bus_a.src_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    bus_a.out_ready = 1'b1;
    bus_a.in_wen    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        check_vec("b2b_valid", 64'(bus_a.out_valid), 64'd1);
        check_vec("b2b_data", 64'(bus_a.out_data), 64'(exp_a[i-1]));
        check_vec("b2b_dest", 64'(bus_a.out_dest), 64'(i));
        check_vec("b2b_wen", 64'(bus_a.out_wen), 64'd1);
        check_vec("b2b_in_ready", 64'(bus_a.in_ready), 64'd1);
      end
      if (i < 4) begin
        bus_a.in_valid = 1'b1;
        bus_a.sel      = i[1:0];
        bus_a.in_dest  = 4'(i + 1);
      end else begin
        bus_a.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_vec("b2b_idle", 64'(bus_a.out_valid), 64'd0);

    // 3: backpressure fills both entries, third request waits for the first drain
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.sel       = 2'(SRC_ALU);
    bus_a.in_dest   = 4'd1;
    @(negedge clk);
    check_vec("bp_in_ready1", 64'(bus_a.in_ready), 64'd1);
    check_vec("bp_data1", 64'(bus_a.out_data), 64'hAAAA);
    bus_a.sel     = 2'(SRC_SHIFT);
    bus_a.in_dest = 4'd2;
    @(negedge clk);
    check_vec("bp_full", 64'(bus_a.in_ready), 64'd0);
    check_vec("bp_hold1", 64'(bus_a.out_data), 64'hAAAA);
    bus_a.sel     = 2'(SRC_REG);
    bus_a.in_dest = 4'd3;
    @(negedge clk);
    check_vec("bp_still_full", 64'(bus_a.in_ready), 64'd0);
    check_vec("bp_hold2", 64'(bus_a.out_data), 64'hAAAA);
    check_vec("bp_hold_dest", 64'(bus_a.out_dest), 64'd1);
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check_vec("bp_drain_data", 64'(bus_a.out_data), 64'hBBBB);
    check_vec("bp_drain_ready", 64'(bus_a.in_ready), 64'd1);
    @(negedge clk);
    check_vec("bp_third_data", 64'(bus_a.out_data), 64'hCCCC);
    check_vec("bp_third_dest", 64'(bus_a.out_dest), 64'd3);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    check_vec("bp_empty", 64'(bus_a.out_valid), 64'd0);

    // 4: illegal select on the 3-source instance, then a legal one
    bus_b.src_data  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.sel       = 2'd3;
    bus_b.in_wen    = 1'b1;
    bus_b.in_dest   = 4'd5;
    @(negedge clk);
    check_vec("ill_valid", 64'(bus_b.out_valid), 64'd1);
    check_vec("ill_data", 64'(bus_b.out_data), 64'd0);
    check_vec("ill_wen", 64'(bus_b.out_wen), 64'd0);
    check_vec("ill_dest", 64'(bus_b.out_dest), 64'd5);
    check_vec("ill_sel_err", 64'(bus_b.sel_err), 64'd1);
    bus_b.sel     = 2'd2;
    bus_b.in_dest = 4'd6;
    @(negedge clk);
    check_vec("leg_data", 64'(bus_b.out_data), 64'hCCCC);
    check_vec("leg_wen", 64'(bus_b.out_wen), 64'd1);
    check_vec("leg_sel_err", 64'(bus_b.sel_err), 64'd0);
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    check_vec("ill_pulse_once", 64'(bus_b.sel_err), 64'd0);

    // 5: reset while both entries are full discards them
    bus_a.src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.sel       = 2'd1;
    @(negedge clk);
    bus_a.sel = 2'd2;
    @(negedge clk);
    check_vec("mid_two", 64'(bus_a.in_ready), 64'd0);
    reset = 1'b1;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    check_vec("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check_vec("mid_rst_data", 64'(bus_a.out_data), 64'd0);
    reset = 1'b0;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check_vec("mid_no_ghost", 64'(bus_a.out_valid), 64'd0);
    bus_a.in_valid = 1'b1;
    bus_a.sel      = 2'd0;
    bus_a.in_dest  = 4'd9;
    @(negedge clk);
    check_vec("mid_new_data", 64'(bus_a.out_data), 64'h1111);
    check_vec("mid_new_dest", 64'(bus_a.out_dest), 64'd9);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    check_vec("mid_after", 64'(bus_a.out_valid), 64'd0);

    // 6: random valid/ready on the 32-bit, 8-source instance
    c_taken = 1'b1;
    for (int cyc = 0; cyc < 10004; cyc++) begin
      @(negedge clk);
      if (cyc >= 10000) begin
        bus_c.in_valid  = 1'b0;
        bus_c.out_ready = 1'b1;
      end else begin
        if (!bus_c.in_valid || c_taken) begin
          for (int k = 0; k < 8; k++) begin
            c_src[k] = $urandom;
            bus_c.src_data[k*32 +: 32] = c_src[k];
          end
          c_sel          = 3'($urandom_range(0, 7));
          bus_c.sel      = c_sel;
          bus_c.in_dest  = 4'($urandom_range(0, 15));
          bus_c.in_wen   = 1'($urandom_range(0, 1));
          bus_c.in_valid = ($urandom_range(0, 3) != 0);
        end
        bus_c.out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      c_taken = bus_c.in_valid && bus_c.in_ready;
      if (c_taken) begin
        sb_q.push_back({c_src[c_sel], bus_c.in_dest, bus_c.in_wen});
      end
      if (bus_c.out_valid && bus_c.out_ready) begin
        if (sb_q.size() == 0) begin
          check_vec("rnd_dup", 64'(bus_c.out_valid), 64'd0);
        end else begin
          exp_c = sb_q.pop_front();
          check_vec("rnd_payload", 64'({bus_c.out_data, bus_c.out_dest, bus_c.out_wen}), 64'(exp_c));
        end
      end
    end
    check_vec("rnd_loss", 64'(sb_q.size()), 64'd0);
    check_vec("rnd_sel_err", 64'(bus_c.sel_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
